// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: register address width, register count,
// default data width and the register address type.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or after the pointer.
// Ports: clk, rst (async high), req[N], advance (grant taken), grant[N] one-hot.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] gidx;
    logic          found;

    always_comb begin
        int idx;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && found) begin
            if (gidx == PW'(N - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= gidx + PW'(1);
            end
        end
    end

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: shares the regfile write port between NUM_REQ sources
// round-robin, registers the winning write, and keeps a pending-write
// scoreboard for decode hazard checks.
// Ports: clk_in, rst_in (async high); req_valid_in/req_rd_in/req_wd_in and
// req_ready_out per requester; issue_valid_in/issue_rd_in set busy bits;
// flush_in clears them; ra_in/rb_in -> ra_busy_out/rb_busy_out;
// write_enable_out/rd_out/wd_out drive the register file.
module riscv_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = riscv_pkg::XLEN
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [NUM_REQ-1:0]      req_valid_in,
    input  logic [NUM_REQ*5-1:0]    req_rd_in,
    input  logic [NUM_REQ*XLEN-1:0] req_wd_in,
    output logic [NUM_REQ-1:0]      req_ready_out,
    input  logic                    issue_valid_in,
    input  logic [4:0]              issue_rd_in,
    input  logic                    flush_in,
    input  logic [4:0]              ra_in,
    input  logic [4:0]              rb_in,
    output logic                    ra_busy_out,
    output logic                    rb_busy_out,
    output logic                    write_enable_out,
    output logic [4:0]              rd_out,
    output logic [XLEN-1:0]         wd_out
);

    import riscv_pkg::*;

    logic [NUM_REQ-1:0]  grant;
    logic                transfer;
    reg_addr_t           sel_rd;
    logic [XLEN-1:0]     sel_wd;
    logic [NUM_REGS-1:1] busy_q;
    logic [NUM_REGS-1:0] busy;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr (
        .clk     (clk_in),
        .rst     (rst_in),
        .req     (req_valid_in),
        .advance (transfer),
        .grant   (grant)
    );

    assign req_ready_out = rst_in ? '0 : grant;
    assign transfer      = |(req_valid_in & req_ready_out);

    always_comb begin
        sel_rd = '0;
        sel_wd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd = req_rd_in[REG_ADDR_W*i +: REG_ADDR_W];
                sel_wd = req_wd_in[XLEN*i +: XLEN];
            end
        end
    end

    // Writes to x0 are consumed but leave the port idle and rd/wd untouched.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            write_enable_out <= 1'b0;
            rd_out           <= '0;
            wd_out           <= '0;
        end else begin
            write_enable_out <= transfer && (sel_rd != '0);
            if (transfer && (sel_rd != '0)) begin
                rd_out <= sel_rd;
                wd_out <= sel_wd;
            end
        end
    end

    // A same-cycle issue beats the retiring write: a newer writer is pending.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q <= '0;
        end else if (flush_in) begin
            busy_q <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (issue_valid_in && issue_rd_in == reg_addr_t'(r)) begin
                    busy_q[r] <= 1'b1;
                end else if (write_enable_out && rd_out == reg_addr_t'(r)) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    assign busy        = {busy_q, 1'b0};
    assign ra_busy_out = busy[ra_in];
    assign rb_busy_out = busy[rb_in];

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Self-checking bench for riscv_wb_arbiter: directed scenarios plus a
// randomized phase, all checked against a behavioural model.
module tb_riscv_wb_arbiter;

    localparam int N  = 3;
    localparam int XL = 32;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic [N-1:0]    req_valid_in;
    logic [N*5-1:0]  req_rd_in;
    logic [N*XL-1:0] req_wd_in;
    logic [N-1:0]    req_ready_out;
    logic            issue_valid_in;
    logic [4:0]      issue_rd_in;
    logic            flush_in;
    logic [4:0]      ra_in;
    logic [4:0]      rb_in;
    logic            ra_busy_out;
    logic            rb_busy_out;
    logic            write_enable_out;
    logic [4:0]      rd_out;
    logic [XL-1:0]   wd_out;

    riscv_wb_arbiter #(.NUM_REQ(N), .XLEN(XL)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .req_valid_in     (req_valid_in),
        .req_rd_in        (req_rd_in),
        .req_wd_in        (req_wd_in),
        .req_ready_out    (req_ready_out),
        .issue_valid_in   (issue_valid_in),
        .issue_rd_in      (issue_rd_in),
        .flush_in         (flush_in),
        .ra_in            (ra_in),
        .rb_in            (rb_in),
        .ra_busy_out      (ra_busy_out),
        .rb_busy_out      (rb_busy_out),
        .write_enable_out (write_enable_out),
        .rd_out           (rd_out),
        .wd_out           (wd_out)
    );

    always #5 clk_in = ~clk_in;

    int compared   = 0;
    int mismatched = 0;

    // Behavioural model state
    int          m_ptr;
    bit          m_busy [32];
    bit          m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_wd;
    logic [N-1:0] last_ready;
    int          last_g;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_we  = 0;
        m_rd  = '0;
        m_wd  = '0;
        for (int r = 0; r < 32; r++) m_busy[r] = 0;
    endtask

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            if (req_valid_in[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // Called at a negedge with inputs applied; ends at the next negedge.
    task automatic cycle();
        int g;
        logic [N-1:0] er;
        logic [4:0] grd;
        #1;
        g  = model_grant();
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        last_ready = req_ready_out;
        last_g     = g;
        chk("ready", 64'(req_ready_out), 64'(er));
        chk("ra_busy", 64'(ra_busy_out), 64'(m_busy[ra_in]));
        chk("rb_busy", 64'(rb_busy_out), 64'(m_busy[rb_in]));
        @(posedge clk_in);
        if (flush_in) begin
            for (int r = 0; r < 32; r++) m_busy[r] = 0;
        end else begin
            if (m_we && m_rd != 0) m_busy[m_rd] = 0;
            if (issue_valid_in && issue_rd_in != 0) m_busy[issue_rd_in] = 1;
        end
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            grd   = req_rd_in[5*g +: 5];
            if (grd != 0) begin
                m_we = 1;
                m_rd = grd;
                m_wd = req_wd_in[XL*g +: XL];
            end else begin
                m_we = 0;
            end
        end else begin
            m_we = 0;
        end
        #1;
        chk("we", 64'(write_enable_out), 64'(m_we));
        chk("rd_out", 64'(rd_out), 64'(m_rd));
        chk("wd_out", 64'(wd_out), 64'(m_wd));
        @(negedge clk_in);
    endtask

    task automatic rand_reqs();
        for (int i = 0; i < N; i++) begin
            if (!req_valid_in[i] || last_ready[i]) begin
                req_valid_in[i]     = ($urandom_range(0, 3) != 0);
                req_rd_in[5*i +: 5] = 5'($urandom_range(0, 31));
                req_wd_in[XL*i +: XL] = $urandom;
            end
        end
    endtask

    initial begin
        rst_in         = 1'b1;
        req_valid_in   = '1;
        req_rd_in      = '0;
        req_wd_in      = '0;
        issue_valid_in = 1'b0;
        issue_rd_in    = '0;
        flush_in       = 1'b0;
        ra_in          = '0;
        rb_in          = '0;
        last_ready     = '0;
        last_g         = -1;
        model_reset();

        // Reset held three cycles
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_ready", 64'(req_ready_out), 64'(0));
        chk("rst_we", 64'(write_enable_out), 64'(0));
        chk("rst_rd", 64'(rd_out), 64'(0));
        chk("rst_wd", 64'(wd_out), 64'(0));
        for (int r = 0; r < 32; r++) begin
            ra_in = 5'(r);
            #1;
            chk("rst_busy", 64'(ra_busy_out), 64'(0));
        end
        req_valid_in = '0;
        ra_in        = '0;
        @(negedge clk_in);
        rst_in = 1'b0;

        // Fairness: all valid, six transfers
        req_valid_in = '1;
        for (int i = 0; i < N; i++) begin
            req_rd_in[5*i +: 5]   = 5'(i + 1);
            req_wd_in[XL*i +: XL] = 32'hA0 + i;
        end
        for (int t = 0; t < 6; t++) begin
            cycle();
            chk("fair_grant", 64'(last_g), 64'(t % 3));
            chk("fair_we", 64'(write_enable_out), 64'(1));
            chk("fair_rd", 64'(rd_out), 64'(t % 3 + 1));
        end
        req_valid_in = '0;
        cycle();
        chk("idle_we", 64'(write_enable_out), 64'(0));

        // Single request from requester 0
        req_valid_in       = 3'b001;
        req_rd_in[4:0]     = 5'd5;
        req_wd_in[31:0]    = 32'hDEADBEEF;
        cycle();
        chk("single_ready", 64'(last_ready), 64'(3'b001));
        chk("single_we", 64'(write_enable_out), 64'(1));
        chk("single_rd", 64'(rd_out), 64'(5));
        chk("single_wd", 64'(wd_out), 64'(32'hDEADBEEF));
        req_valid_in = '0;
        cycle();
        chk("single_we_once", 64'(write_enable_out), 64'(0));

        // Write to x0 is consumed but dropped
        req_valid_in     = 3'b010;
        req_rd_in[9:5]   = 5'd0;
        req_wd_in[63:32] = 32'h1234;
        cycle();
        chk("x0_ready", 64'(last_ready), 64'(3'b010));
        chk("x0_we", 64'(write_enable_out), 64'(0));
        chk("x0_rd_hold", 64'(rd_out), 64'(5));
        chk("x0_wd_hold", 64'(wd_out), 64'(32'hDEADBEEF));
        req_valid_in = '0;

        // Scoreboard set and clear
        issue_valid_in = 1'b1;
        issue_rd_in    = 5'd7;
        cycle();
        issue_valid_in    = 1'b0;
        ra_in             = 5'd7;
        req_valid_in      = 3'b100;
        req_rd_in[14:10]  = 5'd7;
        req_wd_in[95:64]  = 32'h77;
        #1;
        chk("sb_set", 64'(ra_busy_out), 64'(1));
        cycle();
        chk("sb_wr_we", 64'(write_enable_out), 64'(1));
        req_valid_in = '0;
        #1;
        chk("sb_still", 64'(ra_busy_out), 64'(1));
        cycle();
        #1;
        chk("sb_clear", 64'(ra_busy_out), 64'(0));

        // Same-cycle issue and retire of x7: set wins
        issue_valid_in  = 1'b1;
        req_valid_in    = 3'b001;
        req_rd_in[4:0]  = 5'd7;
        cycle();
        req_valid_in = '0;
        chk("sw_we", 64'(write_enable_out), 64'(1));
        chk("sw_rd", 64'(rd_out), 64'(7));
        cycle();
        issue_valid_in = 1'b0;
        #1;
        chk("sb_set_wins", 64'(ra_busy_out), 64'(1));

        // Flush beats same-cycle issue
        flush_in       = 1'b1;
        issue_valid_in = 1'b1;
        issue_rd_in    = 5'd9;
        cycle();
        flush_in       = 1'b0;
        issue_valid_in = 1'b0;
        rb_in          = 5'd9;
        #1;
        chk("flush_ra", 64'(ra_busy_out), 64'(0));
        chk("flush_rb", 64'(rb_busy_out), 64'(0));

        // Randomized phase
        for (int c = 0; c < 400; c++) begin
            rand_reqs();
            issue_valid_in = ($urandom_range(0, 1) == 1);
            issue_rd_in    = 5'($urandom_range(0, 31));
            flush_in       = ($urandom_range(0, 19) == 0);
            ra_in          = 5'($urandom_range(0, 31));
            rb_in          = 5'($urandom_range(0, 31));
            cycle();
        end
        flush_in = 1'b0;

        // Asynchronous reset during an in-flight write
        issue_valid_in  = 1'b1;
        issue_rd_in     = 5'd12;
        req_valid_in    = 3'b001;
        req_rd_in[4:0]  = 5'd9;
        req_wd_in[31:0] = 32'hCAFE;
        cycle();
        chk("mid_we_pre", 64'(write_enable_out), 64'(1));
        issue_valid_in = 1'b0;
        req_valid_in   = '1;
        #1;
        rst_in = 1'b1;
        #1;
        chk("mid_we", 64'(write_enable_out), 64'(0));
        chk("mid_rd", 64'(rd_out), 64'(0));
        chk("mid_ready", 64'(req_ready_out), 64'(0));
        @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        model_reset();
        for (int r = 0; r < 32; r++) begin
            ra_in = 5'(r);
            #1;
            chk("mid_busy", 64'(ra_busy_out), 64'(0));
        end
        cycle();
        chk("mid_ptr", 64'(last_g), 64'(0));
        req_valid_in = '0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
